uart_frame_parser: RTL and testbench

//  Byte-stream frame decoder between uart_rx and the frame-buffer/VGA path, and the control state machine of top.

---
 rtl/uart_frame_parser.sv | 206 ++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: hunts HEADER, checks LEN and XOR checksum, turns CMD_PIX payloads into frame-buffer writes
// Latency: write / ok / err / reply strobes are registered one cycle after the triggering i_rx_done
// Backpressure: none; every byte is consumed on arrival, one ACK/NAK per frame, inter-byte timeout aborts
module uart_frame_parser #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter logic [7:0] CMD_PIX     = 8'h01,
  parameter int         ADDR_W      = 17,
  parameter int         PIX_W       = 12,
  parameter int         TIMEOUT_CYC = 5_000_000,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [PIX_W-1:0]  o_wr_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  output logic              o_frame_ok,
  output logic              o_frame_err,
  output logic [1:0]        o_err_code,
  output logic [7:0]        o_cmd,
  output logic              o_busy
);
  // Address bytes and pixel high byte are stored only as wide as they are used:
  // ADDR_W is expected in 17..24 and PIX_W in 9..16.
  localparam int            TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_LEN_H, S_LEN_L, S_ADDR0, S_ADDR1, S_ADDR2,
    S_PIX_B0, S_PIX_B1, S_DATA, S_CHK
  } state_e;

  state_e            state_q;
  logic [7:0]        cmd_q;      // command of the frame in flight
  logic [7:0]        len_h_q;
  logic [15:0]       rem_q;      // payload bytes still to come (address bytes included)
  logic [7:0]        chk_q;      // running XOR from CMD onwards
  logic [ADDR_W-9:0] addr_hi_q;  // ADDR0/ADDR1 bits that survive truncation
  logic [ADDR_W-1:0] addr_q;     // next pixel address, wraps modulo 2^ADDR_W
  logic [PIX_W-9:0]  pix_hi_q;   // used bits of PIX_B0
  logic [TW-1:0]     tmo_q;

  logic              wr_en_q, tx_valid_q, ok_q, err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;
  logic [7:0]        tx_data_q, last_cmd_q;
  logic [1:0]        err_code_q;

  logic [15:0] len_full_d, rem_dec_d;
  logic [7:0]  chk_d;
  logic        len_bad_d, tmo_hit_d;

  assign len_full_d = {len_h_q, i_rx_data};
  assign rem_dec_d  = rem_q - 16'd1;
  assign chk_d      = chk_q ^ i_rx_data;
  // Pixel frames need 3 address bytes plus whole 2-byte pixels, i.e. LEN >= 3 and odd.
  assign len_bad_d  = (cmd_q == CMD_PIX) && ((len_full_d < 16'd3) || !len_full_d[0]);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit_d  = (state_q != S_IDLE) && !i_rx_done && (tmo_q == TMO_LAST);

  // Frame FSM with registered strobes, reply byte and inter-byte timeout counter
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      len_h_q    <= '0;
      rem_q      <= '0;
      chk_q      <= '0;
      addr_hi_q  <= '0;
      addr_q     <= '0;
      pix_hi_q   <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      last_cmd_q <= '0;
    end else begin
      wr_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      if (state_q == S_IDLE || i_rx_done) tmo_q <= '0;
      else                                tmo_q <= tmo_q + TW'(1);

      if (tmo_hit_d) begin
        err_q      <= 1'b1;
        err_code_q <= 2'd3;
        tx_data_q  <= NAK_BYTE;
        tx_valid_q <= 1'b1;
        tmo_q      <= '0;
        state_q    <= S_IDLE;
      end else if (i_rx_done) begin
        case (state_q)
          S_IDLE: begin
            if (i_rx_data == HEADER) begin
              chk_q   <= '0;
              state_q <= S_CMD;
            end
          end
          S_CMD: begin
            cmd_q   <= i_rx_data;
            chk_q   <= chk_d;
            state_q <= S_LEN_H;
          end
          S_LEN_H: begin
            len_h_q <= i_rx_data;
            chk_q   <= chk_d;
            state_q <= S_LEN_L;
          end
          S_LEN_L: begin
            chk_q <= chk_d;
            rem_q <= len_full_d;
            if (len_bad_d) begin
              err_q      <= 1'b1;
              err_code_q <= 2'd2;
              tx_data_q  <= NAK_BYTE;
              tx_valid_q <= 1'b1;
              state_q    <= S_IDLE;
            end else if (cmd_q == CMD_PIX) begin
              state_q <= S_ADDR0;
            end else if (len_full_d == 16'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_ADDR0: begin
            addr_hi_q[ADDR_W-9:8] <= i_rx_data[ADDR_W-17:0];
            chk_q   <= chk_d;
            rem_q   <= rem_dec_d;
            state_q <= S_ADDR1;
          end
          S_ADDR1: begin
            addr_hi_q[7:0] <= i_rx_data;
            chk_q   <= chk_d;
            rem_q   <= rem_dec_d;
            state_q <= S_ADDR2;
          end
          S_ADDR2: begin
            addr_q  <= {addr_hi_q, i_rx_data};
            chk_q   <= chk_d;
            rem_q   <= rem_dec_d;
            state_q <= (rem_dec_d == 16'd0) ? S_CHK : S_PIX_B0;
          end
          S_PIX_B0: begin
            pix_hi_q <= i_rx_data[PIX_W-9:0];
            chk_q    <= chk_d;
            rem_q    <= rem_dec_d;
            state_q  <= S_PIX_B1;
          end
          S_PIX_B1: begin
            // Writes go out immediately; a later checksum failure only flags the frame.
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= {pix_hi_q, i_rx_data};
            addr_q    <= addr_q + ADDR_W'(1);
            chk_q     <= chk_d;
            rem_q     <= rem_dec_d;
            state_q   <= (rem_dec_d == 16'd0) ? S_CHK : S_PIX_B0;
          end
          S_DATA: begin
            chk_q   <= chk_d;
            rem_q   <= rem_dec_d;
            state_q <= (rem_dec_d == 16'd0) ? S_CHK : S_DATA;
          end
          S_CHK: begin
            if (i_rx_data == chk_q) begin
              ok_q       <= 1'b1;
              err_code_q <= 2'd0;
              last_cmd_q <= cmd_q;
              tx_data_q  <= ACK_BYTE;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'd1;
              tx_data_q  <= NAK_BYTE;
            end
            tx_valid_q <= 1'b1;
            state_q    <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_err_code  = err_code_q;
  assign o_cmd       = last_cmd_q;
  assign o_busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame table plus timeout / reset sequences,
// expected writes and replies queued at stimulus time and popped by a monitor.
`timescale 1ns/1ps
module tb_uart_frame_parser;
  localparam int T = 40;  // shortened inter-byte timeout

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        wr_en, tx_valid, frame_ok, frame_err, busy;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic [7:0]  tx_data, cmd;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  uart_frame_parser #(.TIMEOUT_CYC(T)) dut (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .o_frame_ok(frame_ok),
    .o_frame_err(frame_err), .o_err_code(err_code), .o_cmd(cmd), .o_busy(busy)
  );

  typedef struct {
    logic        is_wr;
    logic [16:0] addr;
    logic [11:0] data;
    logic        ok;
    logic [1:0]  code;
  } ev_t;

  typedef struct {
    logic [127:0] bytes;  // left-justified byte stream
    int           n;
    int           nwr;
    logic [16:0]  wa0, wa1;
    logic [11:0]  wd0, wd1;
    logic         ok;
    logic [1:0]   code;
    logic [7:0]   cmd;    // o_cmd expected after the frame
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[8];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every write or reply strobe must match the head of the queue
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("wr_kind", 32'(1), 32'(e.is_wr));
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (rst_n && (frame_ok || frame_err)) begin
      if (exp_q.size() == 0) chk("unexpected_reply", 32'({frame_ok, frame_err}), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("reply_kind", 32'(0), 32'(e.is_wr));
        chk("frame_ok", 32'(frame_ok), 32'(e.ok));
        chk("frame_err", 32'(frame_err), 32'(!e.ok));
        if (!e.ok) chk("err_code", 32'(err_code), 32'(e.code));
        chk("tx_valid", 32'(tx_valid), 32'(1));
        chk("tx_data", 32'(tx_data), e.ok ? 32'h06 : 32'h15);
      end
    end else if (rst_n && tx_valid) begin
      chk("stray_tx_valid", 32'(tx_valid), 32'(0));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic push_wr(input logic [16:0] a, input logic [11:0] d);
    ev_t e;
    e.is_wr = 1'b1; e.addr = a; e.data = d; e.ok = 1'b0; e.code = 2'd0;
    exp_q.push_back(e);
  endtask

  task automatic push_reply(input logic ok, input logic [1:0] code);
    ev_t e;
    e.is_wr = 1'b0; e.addr = '0; e.data = '0; e.ok = ok; e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_strobes"}, 32'({wr_en, tx_valid, frame_ok, frame_err, busy, err_code}), 32'(0));
    chk({name, "_wr_addr"}, 32'(wr_addr), 32'(0));
    chk({name, "_wr_data"}, 32'(wr_data), 32'(0));
    chk({name, "_tx_data"}, 32'(tx_data), 32'(0));
    chk({name, "_cmd"}, 32'(cmd), 32'(0));
  endtask

  // Apply one table row; gap_cyc idle cycles are inserted before byte gap_pos
  task automatic apply_vec(input int i, input int gap_pos, input int gap_cyc);
    vec_t v;
    v = vecs[i];
    if (v.nwr > 0) push_wr(v.wa0, v.wd0);
    if (v.nwr > 1) push_wr(v.wa1, v.wd1);
    push_reply(v.ok, v.code);
    for (int k = 0; k < v.n; k++) begin
      if (k == gap_pos) repeat (gap_cyc) @(posedge clk);
      send_byte(v.bytes[127-8*k -: 8]);
    end
    wait_drain($sformatf("vec%0d_drain", i), 200);
    chk($sformatf("vec%0d_cmd", i), 32'(cmd), 32'(v.cmd));
    chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{128'hA5010007_0000100A_BC012382_00000000, 12, 2, 17'h00010, 17'h00011, 12'hABC, 12'h123, 1'b1, 2'd0, 8'h01};
    vecs[1] = '{128'hA5010007_0000100A_BC012383_00000000, 12, 2, 17'h00010, 17'h00011, 12'hABC, 12'h123, 1'b0, 2'd1, 8'h01};
    vecs[2] = '{128'hA5010007_01FFFF0F_FF0001F6_00000000, 12, 2, 17'h1FFFF, 17'h00000, 12'hFFF, 12'h001, 1'b1, 2'd0, 8'h01};
    vecs[3] = '{128'hA5020002_11223300_00000000_00000000, 7, 0, '0, '0, '0, '0, 1'b1, 2'd0, 8'h02};
    vecs[4] = '{128'hA5070000_07000000_00000000_00000000, 5, 0, '0, '0, '0, '0, 1'b1, 2'd0, 8'h07};
    vecs[5] = '{128'h00FFA501_00040000_00000000_00000000, 6, 0, '0, '0, '0, '0, 1'b0, 2'd2, 8'h07};
    vecs[6] = '{128'hA5010002_00000000_00000000_00000000, 4, 0, '0, '0, '0, '0, 1'b0, 2'd2, 8'h07};
    vecs[7] = '{128'hA5010003_00000507_00000000_00000000, 8, 0, '0, '0, '0, '0, 1'b1, 2'd0, 8'h01};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) apply_vec(i, -1, 0);

    // Timeout after A5 01 00: NAK code 3, not before the idle budget expires
    push_reply(1'b0, 2'd3);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    repeat (T - 5) @(posedge clk);
    #1;
    chk("tmo_not_early", 32'(exp_q.size()), 32'(1));
    wait_drain("tmo_drain", 4 * T);
    chk("tmo_busy", 32'(busy), 32'(0));
    apply_vec(0, -1, 0);

    // Gap one cycle too long: timeout fires, the late byte is dropped in IDLE
    push_reply(1'b0, 2'd3);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    repeat (T - 1) @(posedge clk);
    send_byte(8'h07);
    wait_drain("tmo_edge_drain", 4 * T);
    chk("tmo_edge_busy", 32'(busy), 32'(0));

    // Byte arriving in the expiry cycle wins; frame completes normally
    apply_vec(0, 3, T - 2);

    // Reset while in PIX_B0: outputs cleared, no NAK, next frame unaffected
    for (int k = 0; k < 7; k++) send_byte(vecs[0].bytes[127-8*k -: 8]);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("mid_reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_queue", 32'(exp_q.size()), 32'(0));
    apply_vec(0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
